// File: rtl/logic_unit_arbiter.sv
// Round-robin front end that shares one bitwise logic unit between NREQ requesters.
// One op is in flight at a time: IDLE accepts, EXEC computes, RESP holds the result until taken.
module logic_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy,
  output logic [15:0]       op_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [2:0]     op_reg, op_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [IDW-1:0] gid_reg, gid_next;
  logic           rsp_valid_reg, rsp_valid_next;
  logic [IDW-1:0] rsp_id_reg, rsp_id_next;
  logic [W-1:0]   rsp_data_reg, rsp_data_next;
  logic [15:0]    op_count_reg, op_count_next;

  logic [2:0]     op_vec   [NREQ];
  logic [W-1:0]   a_vec    [NREQ];
  logic [W-1:0]   b_vec    [NREQ];
  logic [IDW-1:0] cand_idx [NREQ];
  logic           any_valid;
  logic [IDW-1:0] grant_idx;

  // cand_idx[k] is the requester examined k-th in round-robin order, starting at rr_ptr.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      logic [IDW:0] sum;
      assign op_vec[gi]   = req_op[3*gi +: 3];
      assign a_vec[gi]    = req_a[W*gi +: W];
      assign b_vec[gi]    = req_b[W*gi +: W];
      assign sum          = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                    : sum[IDW-1:0];
    end
  endgenerate

  // Scan from the far end so the nearest valid candidate overwrites the rest.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[cand_idx[k]]) begin
        any_valid = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == ST_IDLE && any_valid && !rst)
      req_ready[grant_idx] = 1'b1;
  end

  function automatic logic [W-1:0] logic_fn(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    op_next        = op_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    gid_next       = gid_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_id_next    = rsp_id_reg;
    rsp_data_next  = rsp_data_reg;
    op_count_next  = op_count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_valid) begin
          op_next     = op_vec[grant_idx];
          a_next      = a_vec[grant_idx];
          b_next      = b_vec[grant_idx];
          gid_next    = grant_idx;
          rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_next  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_next  = logic_fn(op_reg, a_reg, b_reg);
        rsp_id_next    = gid_reg;
        rsp_valid_next = 1'b1;
        state_next     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          if (op_count_reg != 16'hFFFF)
            op_count_next = op_count_reg + 16'd1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
      op_count_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_data_reg  <= rsp_data_next;
      op_count_reg  <= op_count_next;
    end
  end

  // Captured operands are only meaningful after a grant, so they need no reset.
  always_ff @(posedge clk) begin
    op_reg  <= op_next;
    a_reg   <= a_next;
    b_reg   <= b_next;
    gid_reg <= gid_next;
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomised and directed bench for logic_unit_arbiter: request-side model pushes expected
// responses, an independent response monitor pops and compares them.
module tb_logic_unit_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;
  logic [15:0]       op_count;

  logic_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour of the logic unit, straight from the op table.
  function automatic logic [W-1:0] ref_f(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           gcyc;
  } exp_t;
  exp_t sb[$];

  // Driver-side request state.
  logic [NREQ-1:0] vld = '0;
  logic [2:0]      d_op [NREQ];
  logic [W-1:0]    d_a  [NREQ];
  logic [W-1:0]    d_b  [NREQ];
  logic [NREQ-1:0] accepted = '0;
  bit              rand_ready = 1'b0;

  // Model state.
  int  model_ptr   = 0;
  bit  outstanding = 1'b0;
  int  grant_cyc   = -10;
  int  done_cyc    = -10;
  int  model_count = 0;
  int  rst_run     = 0;
  bit  rsp_seen    = 1'b0;
  int  rsp_total   = 0;
  int  last_id     = -1;
  logic [W-1:0] last_data;

  // Request side: predict the grant from the round-robin rule and push the expected result.
  initial forever begin
    logic [NREQ-1:0] exp_ready;
    int w;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      model_ptr   = 0;
      outstanding = 1'b0;
      chk("ready_in_reset", 32'(req_ready), 32'd0);
    end else begin
      if (outstanding && done_cyc > grant_cyc && done_cyc < cyc) outstanding = 1'b0;
      chk("busy", 32'(busy), 32'(outstanding));
      exp_ready = '0;
      w = -1;
      if (!outstanding) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (model_ptr + k) % NREQ;
          if (w < 0 && req_valid[idx]) w = idx;
        end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (w >= 0) begin
        e.id   = w;
        e.data = ref_f(d_op[w], d_a[w], d_b[w]);
        e.gcyc = cyc;
        sb.push_back(e);
        model_ptr   = (w + 1) % NREQ;
        outstanding = 1'b1;
        grant_cyc   = cyc;
        accepted[w] = 1'b1;
      end
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rst_run++;
      sb.delete();
      model_count = 0;
      rsp_seen    = 1'b0;
      if (rst_run >= 2) begin
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
      end
    end else begin
      rst_run = 0;
      chk("op_count", 32'(op_count), 32'(model_count));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d data=%0h expected no response", rsp_id, rsp_data);
        end else begin
          if (!rsp_seen) begin
            chk("rsp_latency", 32'(cyc), 32'(sb[0].gcyc + 2));
            rsp_seen = 1'b1;
          end
          chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
          if (rsp_ready) begin
            $display("rsp id=%0d data=%02h cycle=%0d", rsp_id, rsp_data, cyc);
            last_id   = int'(rsp_id);
            last_data = rsp_data;
            rsp_total++;
            void'(sb.pop_front());
            rsp_seen    = 1'b0;
            model_count = (model_count == 65535) ? 65535 : model_count + 1;
            done_cyc    = cyc;
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].gcyc + 2) begin
        checks++;
        errors++;
        $display("FAIL rsp_timeout: got no rsp_valid expected id=%0d by cycle %0d", sb[0].id, sb[0].gcyc + 2);
        void'(sb.pop_front());
        rsp_seen = 1'b0;
        done_cyc = cyc;
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = vld[i];
      req_op[3*i +: 3]  = d_op[i];
      req_a[W*i +: W]   = d_a[i];
      req_b[W*i +: W]   = d_b[i];
    end
  endtask

  task automatic new_req(input int i);
    vld[i]  = 1'b1;
    d_op[i] = 3'($urandom_range(0, 7));
    d_a[i]  = W'($urandom);
    d_b[i]  = W'($urandom);
  endtask

  // mode 0: hold, 1: keep every requester valid, 2: random arrivals and drops
  task automatic cycle_drive(input int mode);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (accepted[i]) begin
        vld[i]      = 1'b0;
        accepted[i] = 1'b0;
      end
      if (mode == 1 && !vld[i]) new_req(i);
      if (mode == 2) begin
        if (!vld[i] && $urandom_range(0, 3) == 0) new_req(i);
        else if (vld[i] && $urandom_range(0, 15) == 0) vld[i] = 1'b0;
      end
    end
    if (rand_ready) rsp_ready = ($urandom_range(0, 9) < 7);
    drive();
  endtask

  task automatic drain();
    int n;
    vld        = '0;
    rand_ready = 1'b0;
    rsp_ready  = 1'b1;
    drive();
    n = 0;
    while ((sb.size() != 0 || outstanding) && n < 30) begin
      cycle_drive(0);
      n++;
    end
    if (sb.size() != 0 || outstanding) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    cycle_drive(0);
  endtask

  task automatic wait_rsp(input int n0);
    int n;
    n = 0;
    while (rsp_total <= n0 && n < 20) begin
      cycle_drive(0);
      n++;
    end
  endtask

  task automatic single_op(input int i, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] kat, input string name);
    int n0;
    n0      = rsp_total;
    vld[i]  = 1'b1;
    d_op[i] = op;
    d_a[i]  = a;
    d_b[i]  = b;
    drive();
    wait_rsp(n0);
    chk({name, "_count"}, 32'(rsp_total), 32'(n0 + 1));
    chk({name, "_id"}, 32'(last_id), 32'(i));
    chk({name, "_data"}, 32'(last_data), 32'(kat));
  endtask

  initial begin
    logic [7:0] kat [8];
    int n, n0;
    kat = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};

    // Reset held for two cycles with every requester valid.
    rst       = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) new_req(i);
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Round robin with all valid: grants 0,1,2,3,0.
    n = 0;
    while (rsp_total < 5 && n < 40) begin
      cycle_drive(1);
      n++;
    end
    chk("rr_op_count", 32'(op_count), 32'd5);
    drain();

    // Single op from requester 1.
    single_op(1, 3'd2, 8'hF0, 8'h3C, 8'hCC, "single");
    drain();

    // Every op code on fixed operands.
    for (int op = 0; op < 8; op++) begin
      single_op($urandom_range(0, NREQ - 1), 3'(op), 8'hA5, 8'h0F, kat[op], $sformatf("op%0d", op));
      drain();
    end

    // Backpressure: result must stay put while other requesters wait.
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) new_req(i);
    drive();
    n0 = rsp_total;
    repeat (8) cycle_drive(0);
    chk("bp_held", 32'(rsp_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    drive();
    wait_rsp(n0);
    chk("bp_released", 32'(rsp_total), 32'(n0 + 1));
    drain();

    // Reset while the op is in EXEC: no response, pointer back to 0.
    new_req(2);
    drive();
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!accepted[2] && n < 5);
    chk("midrst_grant", 32'(accepted[2]), 32'd1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    vld      = '0;
    accepted = '0;
    new_req(1);
    new_req(3);
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0  = rsp_total;
    wait_rsp(n0);
    chk("midrst_next_id", 32'(last_id), 32'd1);
    drain();

    // Random traffic with random backpressure.
    rand_ready = 1'b1;
    repeat (1500) cycle_drive(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000 ns");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
